// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared state encoding and default word width for the config loader
package cfg_pkg;

  localparam int CFG_WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_rb_collect.sv
// rtl/cfg_rb_collect.sv - MSB-first readback collector, flushes full or final partial words
module cfg_rb_collect #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic              bit_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] rb_data_o,
  output logic              rb_valid_o
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);

  logic [WORD_W-1:0] col_q, col_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] word_next;

  assign word_next = {col_q[WORD_W-2:0], bit_i};

  always_comb begin
    col_d      = col_q;
    cnt_d      = cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (clear_i) begin
      col_d = '0;
      cnt_d = '0;
    end else if (sample_i) begin
      if (last_i || cnt_q == LAST_IDX) begin
        // A short final word is moved up to the MSBs, zeros fill the rest.
        rb_data_d  = word_next << (LAST_IDX - cnt_q);
        rb_valid_d = 1'b1;
        col_d      = '0;
        cnt_d      = '0;
      end else begin
        col_d = word_next;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_q      <= '0;
      cnt_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - loads a word-fed bitstream into a serial configuration chain with readback
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_en,
  output logic              config_data_out,
  input  logic              config_data_in,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CHAIN_CW = $clog2(CHAIN_LEN + 1);
  localparam int WORD_CW  = $clog2(WORD_W + 1);
  localparam logic [CHAIN_CW-1:0] LAST_CHAIN_BIT = CHAIN_CW'(CHAIN_LEN - 1);
  localparam logic [WORD_CW-1:0]  LAST_WORD_BIT  = WORD_CW'(WORD_W - 1);

  cfg_state_e          state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CHAIN_CW-1:0] chain_cnt_q, chain_cnt_d;
  logic [WORD_CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                busy_q, done_q;
  logic                shift_fire, start_fire, final_bit;

  // abort wins over everything in the same cycle, so it also masks the strobes.
  assign shift_fire = en & ~abort & (state_q == SHIFT);
  assign start_fire = en & ~abort & start & ((state_q == IDLE) | (state_q == DONE));
  assign final_bit  = (chain_cnt_q == LAST_CHAIN_BIT);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    chain_cnt_d = chain_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    if (abort) begin
      state_d     = IDLE;
      chain_cnt_d = '0;
      bit_cnt_d   = '0;
    end else if (en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d     = LOAD;
            chain_cnt_d = '0;
            bit_cnt_d   = '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            shreg_d   = word_data;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d     = shreg_q << 1;
          chain_cnt_d = chain_cnt_q + CHAIN_CW'(1);
          bit_cnt_d   = bit_cnt_q + WORD_CW'(1);
          if (final_bit) begin
            state_d = DONE;
          end else if (bit_cnt_q == LAST_WORD_BIT) begin
            state_d = LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      chain_cnt_q <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      chain_cnt_q <= chain_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= (state_d == LOAD) || (state_d == SHIFT);
      done_q      <= (state_d == DONE);
    end
  end

  assign word_ready      = en & ~abort & (state_q == LOAD);
  assign config_en       = shift_fire;
  assign config_data_out = shift_fire & shreg_q[WORD_W-1];
  assign busy            = busy_q;
  assign done            = done_q;

  cfg_rb_collect #(
    .WORD_W (WORD_W)
  ) u_rb_collect (
    .clk        (clk),
    .nrst       (nrst),
    .clear_i    (abort | start_fire),
    .sample_i   (shift_fire),
    .bit_i      (config_data_in),
    .last_i     (final_bit),
    .rb_data_o  (rb_data),
    .rb_valid_o (rb_valid)
  );

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - self-checking bench for cfg_loader with a 12-bit chain and 8-bit words
module tb_cfg_loader;

  localparam int CL = 12;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          config_en;
  logic          config_data_out;
  logic          config_data_in;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;

  cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .en              (en),
    .start           (start),
    .abort           (abort),
    .word_data       (word_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .config_en       (config_en),
    .config_data_out (config_data_out),
    .config_data_in  (config_data_in),
    .rb_data         (rb_data),
    .rb_valid        (rb_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Downstream chain: head enters at bit 0, the tail (oldest bit) leaves at bit CL-1.
  logic [CL-1:0] chain_r = '0;
  assign config_data_in = chain_r[CL-1];
  always @(posedge clk) begin
    if (config_en) chain_r <= {chain_r[CL-2:0], config_data_out};
  end

  logic    obs_bits[$];
  logic [WW-1:0] obs_rb[$];
  int      dout_bad = 0;
  always @(negedge clk) begin
    if (config_en) obs_bits.push_back(config_data_out);
    else if (config_data_out) dout_bad <= dout_bad + 1;
    if (rb_valid) obs_rb.push_back(rb_data);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected image: the first CL bits of the word stream, MSB of each word first.
  function automatic logic [CL-1:0] model_bits(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    logic [2*WW-1:0] cat;
    cat = {w0, w1};
    return CL'(cat >> (2 * WW - CL));
  endfunction

  task automatic do_load(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int withhold, input int gap_at, input bit rnd_en,
                         output logic [CL-1:0] obs_v, output logic [WW-1:0] r0,
                         output logic [WW-1:0] r1);
    logic [CL-1:0] snap;
    logic [WW-1:0] words [2];
    int idx, wait_left, gap_left, cyc, en_bad, withheld;
    bit hs, done_seen;
    words[0] = w0;
    words[1] = w1;
    snap = chain_r;
    obs_bits.delete();
    obs_rb.delete();
    idx = 0; wait_left = withhold; gap_left = 3; cyc = 0; en_bad = 0; withheld = 0;
    done_seen = 1'b0;
    en = 1'b1; start = 1'b1; word_valid = 1'b0;
    step();
    start = 1'b0;
    while (!done_seen && cyc < 300) begin
      word_data  = words[idx < 2 ? idx : 1];
      word_valid = (idx < 2) && (wait_left == 0);
      if (gap_at >= 0 && obs_bits.size() == gap_at && gap_left > 0) begin
        en = 1'b0;
        gap_left--;
      end else if (rnd_en) en = ($urandom_range(0, 3) != 0);
      else en = 1'b1;
      @(negedge clk);
      hs = word_valid && word_ready;
      if (!en && (config_en || word_ready)) en_bad++;
      if (config_en && word_ready) en_bad++;
      if (idx == 0 && !word_valid && word_ready && !config_en) begin
        withheld++;
        wait_left--;
      end
      if (done) done_seen = 1'b1;
      @(posedge clk);
      #1;
      if (hs) idx++;
      cyc++;
    end
    en = 1'b1;
    word_valid = 1'b0;
    check({tag, " done_reached"}, 32'(done_seen), 32'd1);
    check({tag, " config_en_count"}, 32'(obs_bits.size()), CL);
    obs_v = '0;
    for (int i = 0; i < obs_bits.size() && i < CL; i++) obs_v[CL-1-i] = obs_bits[i];
    check({tag, " bits_vs_model"}, 32'(obs_v), 32'(model_bits(w0, w1)));
    check({tag, " rb_count"}, 32'(obs_rb.size()), 32'd2);
    r0 = (obs_rb.size() > 0) ? obs_rb[0] : 'x;
    r1 = (obs_rb.size() > 1) ? obs_rb[1] : 'x;
    check({tag, " rb0_vs_chain"}, 32'(r0), 32'(snap[CL-1 -: WW]));
    check({tag, " rb1_vs_chain"}, 32'(r1), 32'({snap[CL-WW-1:0], {(2*WW-CL){1'b0}}}));
    check({tag, " en_gating"}, 32'(en_bad), 32'd0);
    if (withhold > 0) check({tag, " withheld_ready_cycles"}, 32'(withheld), 32'(withhold));
    if (gap_at >= 0) check({tag, " en_gap_taken"}, 32'(gap_left), 32'd0);
  endtask

  typedef struct {
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [CL-1:0] exp_bits;
    logic [WW-1:0] exp_rb0;
    logic [WW-1:0] exp_rb1;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [CL-1:0] ov;
    logic [WW-1:0] r0, r1, w0, w1;
    int cyc;
    bit rnd;

    vecs[0] = '{8'hA5, 8'hC0, 12'b1010_0101_1100, 8'h00, 8'h00};
    vecs[1] = '{8'h00, 8'h00, 12'h000, 8'hA5, 8'hC0};
    vecs[2] = '{8'hFF, 8'hFF, 12'hFFF, 8'h00, 8'h00};
    vecs[3] = '{8'h3C, 8'h7F, 12'h3C7, 8'hFF, 8'hF0};

    #1;
    check("reset_outputs", 32'({word_ready, config_en, config_data_out, rb_data, rb_valid, busy, done}), 32'd0);
    step(); step();
    nrst = 1'b1;
    step();
    check("idle_after_reset", 32'({busy, done, config_en, word_ready}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_load($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, 0, -1, 1'b0, ov, r0, r1);
      check($sformatf("vec%0d bits", i), 32'(ov), 32'(vecs[i].exp_bits));
      check($sformatf("vec%0d rb0", i), 32'(r0), 32'(vecs[i].exp_rb0));
      check($sformatf("vec%0d rb1", i), 32'(r1), 32'(vecs[i].exp_rb1));
      check($sformatf("vec%0d done_held", i), 32'({done, busy}), 32'b10);
    end

    do_load("en_gap", 8'hA5, 8'hC0, 0, 3, 1'b0, ov, r0, r1);
    do_load("withhold", 8'h96, 8'hE1, 4, -1, 1'b0, ov, r0, r1);

    // start during SHIFT must be ignored; abort after the 5th bit returns to idle
    obs_bits.delete();
    start = 1'b1; step(); start = 1'b0;
    word_data = 8'hA5; word_valid = 1'b1; cyc = 0;
    while (obs_bits.size() < 5 && cyc < 100) begin
      start = config_en;
      step();
      cyc++;
    end
    check("abort_reach_5_bits", 32'(cyc < 100), 32'd1);
    start = 1'b0; word_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_config_en", 32'(config_en), 32'd0);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy_done", 32'({busy, done}), 32'd0);
    step(); step(); step();
    check("abort_bit_count", 32'(obs_bits.size()), 32'd5);
    ov = '0;
    for (int i = 0; i < obs_bits.size() && i < 5; i++) ov[4-i] = obs_bits[i];
    check("abort_bits", 32'(ov), 32'b10100);

    // asynchronous reset during the 3rd shifted bit
    obs_bits.delete();
    start = 1'b1; step(); start = 1'b0;
    word_data = 8'h5A; word_valid = 1'b1; cyc = 0;
    while (obs_bits.size() < 2 && cyc < 100) begin
      step();
      cyc++;
    end
    check("reset_pre_config_en", 32'(config_en), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("reset_mid_shift_outputs", 32'({word_ready, config_en, config_data_out, rb_data, rb_valid, busy, done}), 32'd0);
    word_valid = 1'b0;
    step();
    nrst = 1'b1;
    step();
    check("reset_no_more_bits", 32'(obs_bits.size()), 32'd2);
    do_load("after_reset", 8'h6B, 8'hD4, 0, -1, 1'b0, ov, r0, r1);

    for (int t = 0; t < 8; t++) begin
      w0 = WW'($urandom);
      w1 = WW'($urandom);
      rnd = (t % 2) == 1;
      do_load($sformatf("rand%0d", t), w0, w1, rnd ? 0 : int'($urandom_range(0, 3)), -1, rnd, ov, r0, r1);
    end

    check("dout_zero_when_idle", 32'(dout_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 48, meaning the total number of bits in the downstream configuration shift chain (minimum 1).
REQ-002 SHALL have parameter WORD_W, default 8, meaning the width of the bitstream input word and the readback word (minimum 2).
REQ-003 SHALL provide port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide port: nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: en  input  1  global enable; low freezes all state.
REQ-006 SHALL provide port: start  input  1  single-cycle request to begin loading a full chain image.
REQ-007 SHALL provide port: abort  input  1  synchronous request to return to idle.
REQ-008 SHALL provide port: word_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-009 SHALL provide ports: word_valid  input  1, and word_ready  output  1; together they form the word handshake.
REQ-010 SHALL provide port: config_en  output  1  shift strobe to the chain.
REQ-011 SHALL provide port: config_data_out  output  1  serial bit into the chain head.
REQ-012 SHALL provide port: config_data_in  input  1  serial bit returned from the chain tail.
REQ-013 SHALL provide ports: rb_data  output  WORD_W, and rb_valid  output  1; together they carry a readback word.
REQ-014 SHALL provide ports: busy  output  1, and done  output  1; these are status flags.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE/DONE: start=1 and en=1 -> LOAD next cycle, clearing the chain bit counter and done; start SHALL be ignored in LOAD/SHIFT.
REQ-017 LOAD: word_ready = en; when word_valid & word_ready, latch word_data into the shift register and go to SHIFT.
REQ-018 SHIFT with en=1: config_en=1, config_data_out = shreg MSB, shreg shifted left, bit counters +1, one bit per cycle.
REQ-019 SHIFT: after WORD_W bits with the chain not yet complete -> LOAD, giving one bubble cycle per word; word_ready SHALL be 0 in SHIFT.
REQ-020 SHIFT: the cycle shifting bit number CHAIN_LEN -> DONE; unused low bits of the final word SHALL be discarded.
REQ-021 config_en and word_ready SHALL be 0 whenever en=0, and all state and counters SHALL hold.
REQ-022 config_data_out SHALL be 0 whenever config_en=0.
REQ-023 busy=1 in LOAD/SHIFT; done=1 in DONE, held until start or abort.
REQ-024 Readback: on each config_en cycle, sample config_data_in into an MSB-first collector.
REQ-025 Readback: after WORD_W samples, or on the final chain bit, pulse rb_valid for one cycle with rb_data; a partial word SHALL be left-justified and zero-padded. There is no backpressure on readback.
REQ-026 abort=1 (en-independent) SHALL force IDLE next cycle from any state, with config_en=0 and counters cleared; abort has priority over start and the handshake.
REQ-027 Counter widths: chain counter $clog2(CHAIN_LEN+1), word counter $clog2(WORD_W+1); no wrap-around is permitted.

Reset
REQ-028 nrst=0 SHALL asynchronously force IDLE, clear shreg, counters and collector, and drive word_ready, config_en, config_data_out, rb_data, rb_valid, busy and done to 0.
REQ-029 Reset mid-SHIFT SHALL abandon the image without further config_en pulses; the chain keeps its partial contents.

Structure
REQ-030 Shared package cfg_pkg SHALL hold the FSM state enum and the default WORD_W constant.
REQ-031 cfg_loader SHALL be a single module; the readback collector MAY be the sub-module cfg_rb_collect.

Verification (CHAIN_LEN=12, WORD_W=8)
REQ-032 Reset, then start, then words 0xA5 and 0xC0 (valid held) -> config_data_out sequence 1,0,1,0,0,1,0,1,1,1,0,0; exactly 12 config_en cycles; done=1.
REQ-033 Repeat the load with 0x00 and 0x00 after REQ-032 -> rb_data 0xA5 then 0xC0 (partial, zero-padded); done=1.
REQ-034 en=0 for 3 cycles mid-SHIFT -> config_en=0 for those cycles, with the bit sequence unchanged and resumed afterwards.
REQ-035 start asserted during SHIFT -> ignored; abort after the 5th bit -> IDLE next cycle, busy=0, done=0, no further config_en.
REQ-036 nrst asserted on the 3rd bit -> all outputs 0 immediately; a new start then loads a full 12 bits.
REQ-037 word_valid withheld for 4 cycles in LOAD -> word_ready=1 throughout and config_en=0, with the image correct afterwards.
